// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: one-hot HGRANT, HMASTER and HMASTLOCK for NUM_M masters.
// Fixed lowest-index priority by default; define AHB_ARB_RR_EN for round-robin.
module ahb_bus_arbiter #(
    parameter int NUM_M   = 2,
    parameter int DEF_M   = 0,
    parameter int MAX_TEN = 8
) (
    input  logic             i_HCLK,
    input  logic             i_HRESETn,
    input  logic [NUM_M-1:0] i_HBUSREQ,
    input  logic [NUM_M-1:0] i_HLOCK,
    input  logic [1:0]       i_HTRANS,
    input  logic             i_HREADY,
    output logic [NUM_M-1:0] o_HGRANT,
    output logic [3:0]       o_HMASTER,
    output logic             o_HMASTLOCK
);
    localparam logic [3:0] DEF_IDX = 4'(DEF_M);
    localparam logic [7:0] TEN_LIM = 8'(MAX_TEN);

    typedef enum logic [1:0] {PARK, OWN, LOCK} state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [3:0]       r_owner;
    logic [3:0]       w_ownerNext;
    logic [3:0]       r_master;
    logic             r_mastLock;
    logic [7:0]       r_tenure;
    logic [7:0]       w_tenureNext;
    logic [3:0]       w_winner;
    logic             w_found;
    logic             w_arbPoint;
    logic             w_others;
    logic             w_ownerLocked;
    logic [NUM_M-1:0] w_ownerMask;
    logic [NUM_M-1:0] w_eligible;
`ifdef AHB_ARB_RR_EN
    logic [3:0]       r_rrPtr;
`endif

    // Bursts are never split: SEQ and BUSY (HTRANS[0]=1) are not arbitration points.
    always_comb begin
        w_ownerMask   = NUM_M'(1) << r_owner;
        w_arbPoint    = i_HREADY && !i_HTRANS[0];
        w_others      = |(i_HBUSREQ & ~w_ownerMask);
        w_ownerLocked = |(i_HLOCK & i_HBUSREQ & w_ownerMask);
    end

    // An owner whose tenure is used up only competes when nobody else is asking.
    always_comb begin
        w_eligible = i_HBUSREQ;
        if (r_state == OWN && r_tenure == TEN_LIM && w_others)
            w_eligible = i_HBUSREQ & ~w_ownerMask;
        w_found  = 1'b0;
        w_winner = DEF_IDX;
`ifdef AHB_ARB_RR_EN
        for (int i = 0; i < NUM_M; i++) begin
            if (!w_found && w_eligible[i] && 4'(i) > r_rrPtr) begin
                w_found  = 1'b1;
                w_winner = 4'(i);
            end
        end
        for (int i = 0; i < NUM_M; i++) begin
            if (!w_found && w_eligible[i] && 4'(i) <= r_rrPtr) begin
                w_found  = 1'b1;
                w_winner = 4'(i);
            end
        end
`else
        for (int i = 0; i < NUM_M; i++) begin
            if (!w_found && w_eligible[i]) begin
                w_found  = 1'b1;
                w_winner = 4'(i);
            end
        end
`endif
    end

    always_comb begin
        w_stateNext  = r_state;
        w_ownerNext  = r_owner;
        w_tenureNext = r_tenure;
        if (i_HREADY) begin
            if (w_arbPoint) begin
                if (w_ownerLocked) begin
                    w_stateNext = LOCK;
                end else if (w_found) begin
                    w_ownerNext = w_winner;
                    w_stateNext = (|(i_HLOCK & (NUM_M'(1) << w_winner))) ? LOCK : OWN;
                end else begin
                    w_ownerNext = DEF_IDX;
                    w_stateNext = PARK;
                end
            end
            if (w_ownerNext != r_owner || w_stateNext != OWN || !w_others)
                w_tenureNext = '0;
            else if (r_state == OWN && i_HTRANS[1] && r_tenure < TEN_LIM)
                w_tenureNext = r_tenure + 8'd1;
        end
    end

    // HMASTER/HMASTLOCK follow the registered grant at the start of each address phase.
    always_ff @(posedge i_HCLK or negedge i_HRESETn) begin
        if (!i_HRESETn) begin
            r_state    <= PARK;
            r_owner    <= DEF_IDX;
            r_master   <= DEF_IDX;
            r_mastLock <= 1'b0;
            r_tenure   <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_owner  <= w_ownerNext;
            r_tenure <= w_tenureNext;
            if (i_HREADY) begin
                r_master   <= r_owner;
                r_mastLock <= |(i_HLOCK & w_ownerMask);
            end
        end
    end

`ifdef AHB_ARB_RR_EN
    always_ff @(posedge i_HCLK or negedge i_HRESETn) begin
        if (!i_HRESETn)
            r_rrPtr <= '0;
        else if (w_arbPoint && !w_ownerLocked && w_found)
            r_rrPtr <= w_winner;
    end
`endif

    assign o_HGRANT    = w_ownerMask;
    assign o_HMASTER   = r_master;
    assign o_HMASTLOCK = r_mastLock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: a 2-master instance (MAX_TEN=4) and a 3-master instance.
// Expected values follow the arbitration mode selected by AHB_ARB_RR_EN.
module tb_ahb_bus_arbiter;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

`ifdef AHB_ARB_RR_EN
    localparam logic [1:0] EXP_GRANT_BOTH [8] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    localparam logic [3:0] EXP_MASTER_BOTH [8] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1};
    localparam logic [2:0] EXP_GRANT_THREE [11] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001,
                                                    3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    localparam logic [3:0] EXP_MASTER_THREE_E2 = 4'd1;
    localparam logic [2:0] EXP_GRANT_AFTER_RST = 3'b010;
`else
    localparam logic [1:0] EXP_GRANT_BOTH [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
    localparam logic [3:0] EXP_MASTER_BOTH [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
    localparam logic [2:0] EXP_GRANT_THREE [11] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                                                    3'b001, 3'b001, 3'b001, 3'b010, 3'b001};
    localparam logic [3:0] EXP_MASTER_THREE_E2 = 4'd0;
    localparam logic [2:0] EXP_GRANT_AFTER_RST = 3'b001;
`endif

    logic       hClk;
    logic       hResetN;
    logic [1:0] busReq2;
    logic [1:0] lock2;
    logic [1:0] trans;
    logic       ready;
    logic [1:0] grant2;
    logic [3:0] master2;
    logic       mastLock2;
    logic [2:0] busReq3;
    logic [2:0] lock3;
    logic [2:0] grant3;
    logic [3:0] master3;
    logic       mastLock3;

    int compareCount = 0;
    int errorCount   = 0;

    ahb_bus_arbiter #(.NUM_M(2), .DEF_M(0), .MAX_TEN(4)) dut (
        .i_HCLK      (hClk),
        .i_HRESETn   (hResetN),
        .i_HBUSREQ   (busReq2),
        .i_HLOCK     (lock2),
        .i_HTRANS    (trans),
        .i_HREADY    (ready),
        .o_HGRANT    (grant2),
        .o_HMASTER   (master2),
        .o_HMASTLOCK (mastLock2)
    );

    ahb_bus_arbiter #(.NUM_M(3), .DEF_M(0), .MAX_TEN(8)) dut3 (
        .i_HCLK      (hClk),
        .i_HRESETn   (hResetN),
        .i_HBUSREQ   (busReq3),
        .i_HLOCK     (lock3),
        .i_HTRANS    (trans),
        .i_HREADY    (ready),
        .o_HGRANT    (grant3),
        .o_HMASTER   (master3),
        .o_HMASTLOCK (mastLock3)
    );

    initial hClk = 1'b0;
    always #5 hClk = ~hClk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] lck,
                                 input logic [1:0] tr, input logic rdy);
        busReq2 = req;
        lock2   = lck;
        trans   = tr;
        ready   = rdy;
    endtask

    task automatic stepEdge();
        @(posedge hClk);
        #1;
    endtask

    task automatic resetDut();
        hResetN = 1'b0;
        applyStimulus(2'b00, 2'b00, IDLE, 1'b1);
        busReq3 = 3'b000;
        stepEdge();
        hResetN = 1'b1;
    endtask

    initial begin
        hResetN = 1'b0;
        lock3   = 3'b000;
        busReq3 = 3'b000;
        applyStimulus(2'b11, 2'b00, NONSEQ, 1'b1);

        // Reset held with both masters requesting
        stepEdge();
        checkOutput("rst_grant", 32'(grant2), 32'h1);
        checkOutput("rst_master", 32'(master2), 32'h0);
        checkOutput("rst_mastlock", 32'(mastLock2), 32'h0);
        checkOutput("rst_grant3", 32'(grant3), 32'h1);
        hResetN = 1'b1;

        // Both request continuously; tenure limit 4
        for (int k = 0; k < 8; k++) begin
            stepEdge();
            checkOutput($sformatf("both_grant_e%0d", k + 1), 32'(grant2), 32'(EXP_GRANT_BOTH[k]));
            checkOutput($sformatf("both_master_e%0d", k + 1), 32'(master2), 32'(EXP_MASTER_BOTH[k]));
        end

        // M1 alone, one wait state, then drop the request
        resetDut();
        applyStimulus(2'b10, 2'b00, NONSEQ, 1'b1);
        stepEdge();
        checkOutput("m1_grant_e1", 32'(grant2), 32'h2);
        checkOutput("m1_master_e1", 32'(master2), 32'h0);
        applyStimulus(2'b10, 2'b00, NONSEQ, 1'b0);
        stepEdge();
        checkOutput("m1_wait_grant", 32'(grant2), 32'h2);
        checkOutput("m1_wait_master", 32'(master2), 32'h0);
        applyStimulus(2'b10, 2'b00, NONSEQ, 1'b1);
        stepEdge();
        checkOutput("m1_master_e3", 32'(master2), 32'h1);
        applyStimulus(2'b00, 2'b00, IDLE, 1'b1);
        stepEdge();
        checkOutput("m1_park_grant", 32'(grant2), 32'h1);
        checkOutput("m1_park_master", 32'(master2), 32'h1);
        stepEdge();
        checkOutput("m1_park_master2", 32'(master2), 32'h0);

        // M1 INCR4 with two wait states while M0 requests
        resetDut();
        applyStimulus(2'b10, 2'b00, IDLE, 1'b1);
        stepEdge();
        stepEdge();
        checkOutput("burst_master_e2", 32'(master2), 32'h1);
        applyStimulus(2'b10, 2'b00, NONSEQ, 1'b1);
        stepEdge();
        checkOutput("burst_grant_beat1", 32'(grant2), 32'h2);
        applyStimulus(2'b11, 2'b00, SEQ, 1'b0);
        for (int k = 0; k < 2; k++) begin
            stepEdge();
            checkOutput($sformatf("burst_wait_grant%0d", k), 32'(grant2), 32'h2);
            checkOutput($sformatf("burst_wait_master%0d", k), 32'(master2), 32'h1);
        end
        applyStimulus(2'b11, 2'b00, SEQ, 1'b1);
        for (int k = 0; k < 3; k++) begin
            stepEdge();
            checkOutput($sformatf("burst_seq_grant%0d", k + 2), 32'(grant2), 32'h2);
        end
        applyStimulus(2'b11, 2'b00, IDLE, 1'b1);
        stepEdge();
        checkOutput("burst_end_grant", 32'(grant2), 32'h1);
        checkOutput("burst_end_master", 32'(master2), 32'h1);
        stepEdge();
        checkOutput("burst_next_master", 32'(master2), 32'h0);

        // M1 locked for 12 transfers while M0 requests
        resetDut();
        applyStimulus(2'b10, 2'b10, NONSEQ, 1'b1);
        stepEdge();
        checkOutput("lock_grant_e1", 32'(grant2), 32'h2);
        checkOutput("lock_mastlock_e1", 32'(mastLock2), 32'h0);
        applyStimulus(2'b11, 2'b10, NONSEQ, 1'b1);
        for (int k = 0; k < 12; k++) begin
            stepEdge();
            checkOutput($sformatf("lock_grant_t%0d", k), 32'(grant2), 32'h2);
            checkOutput($sformatf("lock_mastlock_t%0d", k), 32'(mastLock2), 32'h1);
            checkOutput($sformatf("lock_master_t%0d", k), 32'(master2), 32'h1);
        end
        applyStimulus(2'b01, 2'b00, IDLE, 1'b1);
        stepEdge();
        checkOutput("unlock_grant", 32'(grant2), 32'h1);
        checkOutput("unlock_mastlock", 32'(mastLock2), 32'h0);
        stepEdge();
        checkOutput("unlock_master", 32'(master2), 32'h0);

        // Asynchronous reset in the middle of a locked sequence
        applyStimulus(2'b10, 2'b10, NONSEQ, 1'b1);
        stepEdge();
        stepEdge();
        checkOutput("relock_mastlock", 32'(mastLock2), 32'h1);
        #2 hResetN = 1'b0;
        #1;
        checkOutput("async_grant", 32'(grant2), 32'h1);
        checkOutput("async_master", 32'(master2), 32'h0);
        checkOutput("async_mastlock", 32'(mastLock2), 32'h0);

        // Three masters all requesting singles
        resetDut();
        applyStimulus(2'b00, 2'b00, NONSEQ, 1'b1);
        busReq3 = 3'b111;
        for (int k = 0; k < 11; k++) begin
            stepEdge();
            checkOutput($sformatf("three_grant_e%0d", k + 1), 32'(grant3), 32'(EXP_GRANT_THREE[k]));
            if (k == 1)
                checkOutput("three_master_e2", 32'(master3), 32'(EXP_MASTER_THREE_E2));
        end
        #2 hResetN = 1'b0;
        #1;
        checkOutput("three_async_grant", 32'(grant3), 32'h1);
        checkOutput("three_async_mastlock", 32'(mastLock3), 32'h0);
        stepEdge();
        hResetN = 1'b1;
        stepEdge();
        checkOutput("three_post_rst_grant", 32'(grant3), 32'(EXP_GRANT_AFTER_RST));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end
endmodule
